// File: rtl/register_rename.sv
// ============================================================================
// register_rename
// In-order rename stage: maps rs/rd to physical tags from a circular free list.
// Rev 1.0
// ============================================================================
`default_nettype none

module register_rename #(
   parameter int NUM_REG       = 32,
   parameter int NUM_REG_LOG2  = $clog2(NUM_REG),
   parameter int NUM_TAGS      = 64,
   parameter int NUM_TAGS_LOG2 = $clog2(NUM_TAGS),
   parameter int NUM_FREE      = NUM_TAGS - NUM_REG,
   parameter int FREE_LOG2     = $clog2(NUM_FREE)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     stall_in,
   input  logic                     in_valid,
   input  logic [7:0]               pc,
   input  logic [NUM_REG_LOG2-1:0]  arch_rs [0:1],
   input  logic [NUM_REG_LOG2-1:0]  arch_rd,
   input  logic                     retire_valid,
   input  logic [NUM_REG_LOG2-1:0]  retire_reg,
   input  logic [NUM_TAGS_LOG2-1:0] retire_tag,
   input  logic                     flush,
   output logic                     rename_stall,
   output logic                     out_valid,
   output logic [7:0]               out_pc,
   output logic [NUM_REG_LOG2-1:0]  out_arch_rd,
   output logic [NUM_TAGS_LOG2-1:0] out_tag_rd,
   output logic [NUM_TAGS_LOG2-1:0] out_old_tag_rd,
   output logic [NUM_TAGS_LOG2-1:0] out_tag_rs [0:1],
   output logic [FREE_LOG2:0]       free_count
);

   logic [NUM_TAGS_LOG2-1:0] rat_q  [NUM_REG];
   logic [NUM_TAGS_LOG2-1:0] crat_q [NUM_REG];
   logic [NUM_TAGS_LOG2-1:0] fl_q   [NUM_FREE];
   logic [FREE_LOG2:0]       head_q, head_d, chead_q, chead_d, tail_q, tail_d;

   logic                     out_valid_q;
   logic [7:0]               out_pc_q;
   logic [NUM_REG_LOG2-1:0]  out_arch_rd_q;
   logic [NUM_TAGS_LOG2-1:0] out_tag_rd_q, out_old_tag_rd_q;
   logic [NUM_TAGS_LOG2-1:0] out_tag_rs_q [0:1];

   logic                     need_tag, fire, alloc, retire_en;
   logic [NUM_TAGS_LOG2-1:0] new_tag;

   always_comb begin
      need_tag     = in_valid & (arch_rd != '0);
      free_count   = tail_q - head_q;
      rename_stall = stall_in | flush | (need_tag & (free_count == '0));
      fire         = in_valid & ~rename_stall;
      alloc        = fire & need_tag;
      retire_en    = retire_valid & (retire_reg != '0) & (retire_tag != '0);
      new_tag      = fl_q[head_q[FREE_LOG2-1:0]];
      chead_d      = chead_q + {{FREE_LOG2{1'b0}}, retire_en};
      tail_d       = tail_q + {{FREE_LOG2{1'b0}}, retire_en};
      // Flush rewinds allocation to the committed point, including this cycle's retire
      head_d       = flush ? chead_d : head_q + {{FREE_LOG2{1'b0}}, alloc};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_REG; i++) begin
            rat_q[i]  <= NUM_TAGS_LOG2'(i);
            crat_q[i] <= NUM_TAGS_LOG2'(i);
         end
         for (int k = 0; k < NUM_FREE; k++) begin
            fl_q[k] <= NUM_TAGS_LOG2'(NUM_REG + k);
         end
         head_q  <= '0;
         chead_q <= '0;
         tail_q  <= (FREE_LOG2+1)'(NUM_FREE);
      end else begin
         head_q  <= head_d;
         chead_q <= chead_d;
         tail_q  <= tail_d;
         if (retire_en) begin
            fl_q[tail_q[FREE_LOG2-1:0]] <= crat_q[retire_reg];
            crat_q[retire_reg]          <= retire_tag;
         end
         if (flush) begin
            for (int i = 0; i < NUM_REG; i++) begin
               rat_q[i] <= (retire_en && retire_reg == NUM_REG_LOG2'(i)) ? retire_tag : crat_q[i];
            end
         end else if (alloc) begin
            rat_q[arch_rd] <= new_tag;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q      <= 1'b0;
         out_pc_q         <= '0;
         out_arch_rd_q    <= '0;
         out_tag_rd_q     <= '0;
         out_old_tag_rd_q <= '0;
         out_tag_rs_q[0]  <= '0;
         out_tag_rs_q[1]  <= '0;
      end else if (flush) begin
         out_valid_q <= 1'b0;
      end else if (!stall_in) begin
         if (fire) begin
            out_valid_q      <= 1'b1;
            out_pc_q         <= pc;
            out_arch_rd_q    <= arch_rd;
            out_tag_rs_q[0]  <= rat_q[arch_rs[0]];
            out_tag_rs_q[1]  <= rat_q[arch_rs[1]];
            out_tag_rd_q     <= need_tag ? new_tag : '0;
            out_old_tag_rd_q <= need_tag ? rat_q[arch_rd] : '0;
         end else begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign out_valid      = out_valid_q;
   assign out_pc         = out_pc_q;
   assign out_arch_rd    = out_arch_rd_q;
   assign out_tag_rd     = out_tag_rd_q;
   assign out_old_tag_rd = out_old_tag_rd_q;
   assign out_tag_rs[0]  = out_tag_rs_q[0];
   assign out_tag_rs[1]  = out_tag_rs_q[1];

endmodule

`default_nettype wire

// File: tb/tb_register_rename.sv
// ============================================================================
// tb_register_rename
// Table vectors, corner sequences and random traffic against a queue-based model.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_register_rename;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       stall_in = 1'b0, in_valid = 1'b0, retire_valid = 1'b0, flush = 1'b0;
   logic [7:0] pc = '0;
   logic [4:0] arch_rs [0:1];
   logic [4:0] arch_rd = '0, retire_reg = '0;
   logic [5:0] retire_tag = '0;
   logic       rename_stall, out_valid;
   logic [7:0] out_pc;
   logic [4:0] out_arch_rd;
   logic [5:0] out_tag_rd, out_old_tag_rd;
   logic [5:0] out_tag_rs [0:1];
   logic [5:0] free_count;

   register_rename dut (
      .clk(clk), .rst(rst), .stall_in(stall_in), .in_valid(in_valid), .pc(pc),
      .arch_rs(arch_rs), .arch_rd(arch_rd), .retire_valid(retire_valid),
      .retire_reg(retire_reg), .retire_tag(retire_tag), .flush(flush),
      .rename_stall(rename_stall), .out_valid(out_valid), .out_pc(out_pc),
      .out_arch_rd(out_arch_rd), .out_tag_rd(out_tag_rd), .out_old_tag_rd(out_old_tag_rd),
      .out_tag_rs(out_tag_rs), .free_count(free_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      int iv, pc, rs0, rs1, rd, sin, rv, rreg, rtag, fl;
      int es, efc, eov, ers0, ers1, erd, eold;
   } vec_t;

   typedef struct { int rd; int tag; } ent_t;

   int   total = 0, bad = 0;
   int   m_rat [32], m_crat [32];
   int   fq [$];
   ent_t specq [$];
   int   m_ov, m_pc, m_ard, m_trd, m_old, m_trs0, m_trs1;
   vec_t tbl [13];

   function automatic vec_t mk(int iv, int pc, int rs0, int rs1, int rd, int sin, int rv,
                               int rreg, int rtag, int fl, int es, int efc, int eov,
                               int ers0, int ers1, int erd, int eold);
      vec_t v;
      v.iv = iv; v.pc = pc; v.rs0 = rs0; v.rs1 = rs1; v.rd = rd; v.sin = sin; v.rv = rv;
      v.rreg = rreg; v.rtag = rtag; v.fl = fl; v.es = es; v.efc = efc; v.eov = eov;
      v.ers0 = ers0; v.ers1 = ers1; v.erd = erd; v.eold = eold;
      return v;
   endfunction

   task automatic check(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) begin
         m_rat[i] = i;
         m_crat[i] = i;
      end
      fq.delete();
      for (int k = 0; k < 32; k++) fq.push_back(32 + k);
      specq.delete();
      m_ov = 0; m_pc = 0; m_ard = 0; m_trd = 0; m_old = 0; m_trs0 = 0; m_trs1 = 0;
   endtask

   // Free tags live in fq; allocated-but-uncommitted tags in specq, oldest first.
   task automatic model_step(input vec_t v);
      bit need, stall, fire;
      int t;
      int tmp [$];
      need  = (v.iv != 0) && (v.rd != 0);
      stall = (v.sin != 0) || (v.fl != 0) || (need && fq.size() == 0);
      fire  = (v.iv != 0) && !stall;
      if (v.fl != 0) m_ov = 0;
      else if (v.sin == 0) begin
         if (fire) begin
            m_ov = 1; m_pc = v.pc; m_ard = v.rd;
            m_trs0 = m_rat[v.rs0]; m_trs1 = m_rat[v.rs1];
            if (need) begin
               t = fq.pop_front();
               m_trd = t; m_old = m_rat[v.rd]; m_rat[v.rd] = t;
               specq.push_back('{rd: v.rd, tag: t});
            end else begin
               m_trd = 0; m_old = 0;
            end
         end else m_ov = 0;
      end
      if (v.rv != 0 && v.rreg != 0 && v.rtag != 0) begin
         fq.push_back(m_crat[v.rreg]);
         m_crat[v.rreg] = v.rtag;
         if (specq.size() > 0) void'(specq.pop_front());
      end
      if (v.fl != 0) begin
         m_rat = m_crat;
         foreach (specq[i]) tmp.push_back(specq[i].tag);
         foreach (fq[i]) tmp.push_back(fq[i]);
         fq = tmp;
         specq.delete();
      end
   endtask

   // Called #1 after a rising edge; returns #1 after the next one.
   task automatic apply(input vec_t v, input bit chk);
      bit need, stall;
      in_valid = v.iv[0]; pc = 8'(v.pc); arch_rs[0] = 5'(v.rs0); arch_rs[1] = 5'(v.rs1);
      arch_rd = 5'(v.rd); stall_in = v.sin[0]; retire_valid = v.rv[0];
      retire_reg = 5'(v.rreg); retire_tag = 6'(v.rtag); flush = v.fl[0];
      #3;
      need  = (v.iv != 0) && (v.rd != 0);
      stall = (v.sin != 0) || (v.fl != 0) || (need && fq.size() == 0);
      check("rename_stall", int'(rename_stall), int'(stall));
      check("free_count", int'(free_count), fq.size());
      check("fc_bound", int'(free_count <= 6'd32), 1);
      if (chk) begin
         if (v.es >= 0)  check("tbl_stall", int'(rename_stall), v.es);
         if (v.efc >= 0) check("tbl_fc", int'(free_count), v.efc);
      end
      model_step(v);
      @(posedge clk); #1;
      check("out_valid", int'(out_valid), m_ov);
      check("out_pc", int'(out_pc), m_pc);
      check("out_arch_rd", int'(out_arch_rd), m_ard);
      check("out_tag_rd", int'(out_tag_rd), m_trd);
      check("out_old_tag_rd", int'(out_old_tag_rd), m_old);
      check("out_tag_rs0", int'(out_tag_rs[0]), m_trs0);
      check("out_tag_rs1", int'(out_tag_rs[1]), m_trs1);
      if (chk) begin
         if (v.eov >= 0)  check("tbl_ov", int'(out_valid), v.eov);
         if (v.ers0 >= 0) check("tbl_rs0", int'(out_tag_rs[0]), v.ers0);
         if (v.ers1 >= 0) check("tbl_rs1", int'(out_tag_rs[1]), v.ers1);
         if (v.erd >= 0)  check("tbl_rd", int'(out_tag_rd), v.erd);
         if (v.eold >= 0) check("tbl_old", int'(out_old_tag_rd), v.eold);
      end
   endtask

   // Asserted between edges: outputs must clear without waiting for a clock.
   task automatic do_reset();
      in_valid = 0; stall_in = 0; retire_valid = 0; flush = 0;
      rst = 1'b1;
      #2;
      check("rst_ov", int'(out_valid), 0);
      check("rst_tag_rd", int'(out_tag_rd), 0);
      check("rst_old", int'(out_old_tag_rd), 0);
      check("rst_fc", int'(free_count), 32);
      check("rst_stall", int'(rename_stall), 0);
      model_reset();
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   function automatic vec_t ren(int rs0, int rs1, int rd);
      return mk(1, $urandom_range(0, 255), rs0, rs1, rd, 0, 0, 0, 0, 0,
                -1, -1, -1, -1, -1, -1, -1);
   endfunction

   initial begin
      vec_t v;
      arch_rs[0] = '0; arch_rs[1] = '0;
      //             iv pc rs0 rs1 rd sin rv rreg rtag fl | stall fc ov rs0 rs1 rd old
      tbl[0]  = mk(1, 10, 1, 2, 3, 0, 0, 0, 0,  0,  0, 32, 1, 1,  2,  32, 3);
      tbl[1]  = mk(1, 11, 0, 0, 5, 0, 0, 0, 0,  0,  0, 31, 1, 0,  0,  33, 5);
      tbl[2]  = mk(1, 12, 5, 3, 5, 0, 0, 0, 0,  0,  0, 30, 1, 33, 32, 34, 33);
      tbl[3]  = mk(1, 13, 3, 4, 0, 0, 0, 0, 0,  0,  0, 29, 1, 32, 4,  0,  0);
      tbl[4]  = mk(1, 14, 1, 1, 6, 1, 0, 0, 0,  0,  1, 29, 1, 32, 4,  0,  0);
      tbl[5]  = mk(1, 14, 1, 1, 6, 1, 0, 0, 0,  0,  1, 29, 1, 32, 4,  0,  0);
      tbl[6]  = mk(1, 14, 1, 1, 6, 1, 0, 0, 0,  0,  1, 29, 1, 32, 4,  0,  0);
      tbl[7]  = mk(1, 14, 1, 1, 6, 0, 0, 0, 0,  0,  0, 29, 1, 1,  1,  35, 6);
      tbl[8]  = mk(0, 0,  0, 0, 0, 0, 0, 0, 0,  0,  0, 28, 0, 1,  1,  35, 6);
      tbl[9]  = mk(0, 0,  0, 0, 0, 0, 1, 3, 32, 0,  0, 28, 0, 1,  1,  35, 6);
      tbl[10] = mk(0, 0,  0, 0, 0, 0, 1, 5, 0,  0,  0, 29, 0, 1,  1,  35, 6);
      tbl[11] = mk(0, 0,  0, 0, 0, 0, 1, 5, 33, 1,  1, 29, 0, 1,  1,  35, 6);
      tbl[12] = mk(1, 15, 5, 3, 7, 0, 0, 0, 0,  0,  0, 32, 1, 33, 32, 34, 7);

      model_reset();
      #12;
      do_reset();
      foreach (tbl[i]) apply(tbl[i], 1'b1);

      // Exhaustion, then a retire frees tag 1 one cycle too late to bypass.
      do_reset();
      for (int i = 0; i < 32; i++) apply(ren(0, 0, 1), 1'b0);
      check("exh_fc", int'(free_count), 0);
      apply(mk(1, 40, 0, 0, 2, 0, 0, 0, 0, 0, 1, 0, 0, -1, -1, -1, -1), 1'b1);
      apply(mk(1, 40, 0, 0, 2, 0, 1, 1, 32, 0, 1, 0, 0, -1, -1, -1, -1), 1'b1);
      apply(mk(1, 40, 0, 0, 2, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 2), 1'b1);

      // Flush recovery to the committed map.
      do_reset();
      apply(mk(1, 50, 0, 0, 1, 0, 0, 0, 0, 0, 0, 32, 1, 0, 0, 32, 1), 1'b1);
      apply(mk(1, 51, 0, 0, 2, 0, 0, 0, 0, 0, 0, 31, 1, 0, 0, 33, 2), 1'b1);
      apply(mk(0, 0, 0, 0, 0, 0, 1, 1, 32, 0, 0, 30, 0, -1, -1, -1, -1), 1'b1);
      apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 31, 0, -1, -1, -1, -1), 1'b1);
      apply(mk(1, 52, 1, 2, 4, 0, 0, 0, 0, 0, 0, 32, 1, 32, 2, 33, 4), 1'b1);

      // Random traffic; retires always pop the oldest outstanding rename.
      for (int n = 0; n < 3000; n++) begin
         if (n == 1500) do_reset();
         v = mk(($urandom % 4) != 0 ? 1 : 0, $urandom_range(0, 255), $urandom_range(0, 31),
                $urandom_range(0, 31), ($urandom % 8 == 0) ? 0 : $urandom_range(1, 31),
                ($urandom % 6 == 0) ? 1 : 0, 0, 0, 0, 0, -1, -1, -1, -1, -1, -1, -1);
         if (v.sin == 0 && $urandom % 50 == 0) v.fl = 1;
         if (specq.size() > 0 && $urandom % 3 != 0) begin
            v.rv = 1; v.rreg = specq[0].rd; v.rtag = specq[0].tag;
         end else if ($urandom % 10 == 0) begin
            v.rv = 1; v.rreg = 0; v.rtag = $urandom_range(1, 63);
         end
         apply(v, 1'b0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
